instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning the instruction buffer entries and the in-flight credit limit.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port imem_req_valid, output, 1 bit: fetch request valid.
REQ-006 SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-007 SHALL have port imem_req_addr, output, 32 bits: word-aligned fetch address.
REQ-008 SHALL have port imem_resp_valid, input, 1 bit: response valid; responses return in order, cannot be back-pressured, and arrive no earlier than the cycle after acceptance.
REQ-009 SHALL have port imem_resp_data, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port redirect_valid, input, 1 bit: control-flow redirect (branch, jump or trap).
REQ-011 SHALL have port redirect_pc, input, 32 bits: new fetch address.
REQ-012 SHALL have port id_valid, output, 1 bit: an instruction is offered to the decode stage.
REQ-013 SHALL have port id_ready, input, 1 bit: the decode stage consumes the offered instruction.
REQ-014 SHALL have port id_ins, output, 32 bits: instruction word sent to the decoder's ins input.
REQ-015 SHALL have port id_pc, output, 32 bits: address of id_ins.

Function
REQ-016 SHALL hold pc, a FIFO of {pc, ins} with BUF_DEPTH entries, an inflight counter and a drop counter.
REQ-017 SHALL drive imem_req_addr = pc and imem_req_valid = (inflight + occupancy < BUF_DEPTH) && !redirect_valid.
REQ-018 SHALL treat a request as accepted when imem_req_valid && imem_req_ready; on acceptance, pc <= pc + 4 (modulo 2^32, wrapping 32'hFFFF_FFFC to 0) and inflight increments.
REQ-019 SHALL keep pc and imem_req_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-020 SHALL, for each response with drop=0, push {issued address, imem_resp_data} into the FIFO and decrement inflight; the credit rule in REQ-017 guarantees the FIFO is never full at a push.
REQ-021 SHALL drive id_valid = (occupancy>0) && !redirect_valid, with id_ins and id_pc taken from the FIFO head.
REQ-022 SHALL pop the head when id_valid && id_ready; a push and a pop in the same cycle leave occupancy unchanged.
REQ-023 SHALL keep id_ins and id_pc stable while id_valid=1 and id_ready=0.
REQ-024 SHALL, when redirect_valid=1, set pc <= {redirect_pc[31:2], 2'b00}, flush the FIFO, and set drop <= inflight_next, where inflight_next is inflight after any same-cycle response is retired.
REQ-025 SHALL, for each response while drop>0, discard the data and decrement both drop and inflight.
REQ-026 SHALL make a redirect win over a simultaneous pop; a same-cycle response is discarded.
REQ-027 SHALL restart fetch at the redirect target in the cycle after redirect_valid, provided credits are available.
REQ-028 SHALL accept back-to-back redirects; the last one determines pc.
REQ-029 SHALL let occupancy, inflight and drop each range only 0..BUF_DEPTH, with no overflow or underflow under legal stimulus.

Reset
REQ-030 SHALL, while rst_n=0 and immediately on its assertion, set pc=RESET_PC, occupancy=0, inflight=0, drop=0, imem_req_valid=0 and id_valid=0, with id_ins=0 and id_pc=0.
REQ-031 SHALL abandon any in-flight request when reset is asserted mid-operation; the environment guarantees that no stale response follows reset release.
REQ-032 SHALL assert imem_req_valid with address RESET_PC in the first cycle after rst_n rises.

Verification
REQ-033 Streaming: memory always ready, 1-cycle latency, id_ready=1 -> id_pc sequence 0,4,8,... at 1 instruction per cycle after initial latency; id_ins matches memory contents.
REQ-034 Decode stall: id_ready=0 for 10 cycles -> FIFO fills to 2, imem_req_valid=0, id_ins/id_pc frozen; release -> no loss or duplication.
REQ-035 Redirect with 2 in flight: redirect_pc=32'h0000_0103 -> both stale responses dropped, next accepted request address 32'h0000_0100, first id_pc=32'h0000_0100.
REQ-036 Redirect coinciding with response and pop -> response discarded, no pop counted, id_valid=0 that cycle.
REQ-037 Wrap: redirect to 32'hFFFF_FFFC -> following fetch addresses FFFF_FFFC then 0000_0000.
REQ-038 Async reset mid-stream with occupancy=2 -> all outputs reach reset values without a clock edge; first request after release is RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : Credit-limited instruction fetch with in-order response buffer,
//            redirect flush and stale-response drop counting.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_ins,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam logic [CW:0]   c_depth    = (CW+1)'(BUF_DEPTH);
    localparam logic [PW-1:0] c_last_ptr = PW'(BUF_DEPTH - 1);

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [31:0]   r_fifo_pc  [BUF_DEPTH];
    logic [31:0]   r_fifo_ins [BUF_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop;

    logic [CW:0]   w_credit_used;
    logic          w_req_fire;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_infl_retired;
    logic [CW-1:0] w_infl_next;
    logic [31:0]   w_redirect_tgt;
    logic [PW-1:0] w_wr_ptr_inc;
    logic [PW-1:0] w_rd_ptr_inc;

    always_comb begin
        w_credit_used  = {1'b0, r_inflight} + {1'b0, r_count};
        // rst_n gating keeps the request low while reset is held
        imem_req_valid = rst_n && (w_credit_used < c_depth) && !redirect_valid;
        imem_req_addr  = r_pc;
        w_req_fire     = imem_req_valid && imem_req_ready;

        id_valid       = (r_count != '0) && !redirect_valid;
        id_ins         = r_fifo_ins[r_rd_ptr];
        id_pc          = r_fifo_pc[r_rd_ptr];
        w_pop          = id_valid && id_ready;

        w_push         = imem_resp_valid && (r_drop == '0) && !redirect_valid;
        w_infl_retired = r_inflight - CW'(imem_resp_valid);
        w_infl_next    = w_infl_retired + CW'(w_req_fire);
        w_redirect_tgt = {redirect_pc[31:2], 2'b00};

        w_wr_ptr_inc   = (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_inc   = (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= '0;
            r_drop     <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                r_fifo_pc[i]  <= '0;
                r_fifo_ins[i] <= '0;
            end
        end else if (redirect_valid) begin
            // Every request still outstanding after this cycle's response is stale
            r_pc       <= w_redirect_tgt;
            r_resp_pc  <= w_redirect_tgt;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_inflight <= w_infl_retired;
            r_drop     <= w_infl_retired;
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + 32'd4;
            end
            r_inflight <= w_infl_next;
            if (imem_resp_valid && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
            // Surviving responses are sequential from the last redirect target
            if (w_push) begin
                r_fifo_pc[r_wr_ptr]  <= r_resp_pc;
                r_fifo_ins[r_wr_ptr] <= imem_resp_data;
                r_wr_ptr             <= w_wr_ptr_inc;
                r_resp_pc            <= r_resp_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_inc;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed self-checking bench for instr_fetch with a latency-
//            configurable in-order memory model.
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ins;
    logic [31:0] id_pc;

    instr_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_ins          (id_ins),
        .id_pc           (id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pq[$];
    logic [31:0] acc_log[$];
    int          cyc;
    int          lat;
    int          n_pops;
    logic [31:0] exp_pc;
    int          n_checks;
    int          n_errors;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_resp();
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = memf(pq[0].addr);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
    endtask

    // One clock: sample handshakes before the edge, update model after it
    task automatic tick();
        logic        acc, rsp, pop;
        logic [31:0] a, ppc, pins;
        #1;
        acc  = imem_req_valid && imem_req_ready;
        a    = imem_req_addr;
        rsp  = imem_resp_valid;
        pop  = id_valid && id_ready;
        ppc  = id_pc;
        pins = id_ins;
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            check_eq("id_pc", ppc, exp_pc);
            check_eq("id_ins", pins, memf(exp_pc));
            exp_pc = exp_pc + 32'd4;
            n_pops++;
        end
        if (rsp && pq.size() > 0) void'(pq.pop_front());
        if (acc) begin
            pq.push_back('{a, cyc + lat - 1});
            acc_log.push_back(a);
        end
        drive_resp();
    endtask

    task automatic run_until_pops(input int target, input string tag, input int budget);
        for (int i = 0; i < budget && n_pops < target; i++) tick();
        check_eq(tag, 32'(n_pops >= target), 32'd1);
    endtask

    initial begin
        logic [31:0] hold_pc, hold_ins, hold_addr;
        int          n0;
        n_checks = 0; n_errors = 0; cyc = 0; lat = 1; n_pops = 0; exp_pc = '0;
        rst_n = 1'b0; imem_req_ready = 1'b1; imem_resp_valid = 1'b0; imem_resp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b1;

        // Reset state
        #3;
        check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check_eq("rst_id_valid", 32'(id_valid), 32'd0);
        check_eq("rst_id_ins", id_ins, 32'd0);
        check_eq("rst_id_pc", id_pc, 32'd0);
        check_eq("rst_addr", imem_req_addr, 32'd0);
        @(posedge clk); @(posedge clk); #3;
        rst_n = 1'b1;
        #1;
        check_eq("rel_req_valid", 32'(imem_req_valid), 32'd1);
        check_eq("rel_addr", imem_req_addr, 32'd0);

        // Streaming, 1-cycle memory
        run_until_pops(6, "stream_cnt", 40);

        // Decode stall fills the buffer and freezes the head
        id_ready = 1'b0;
        tick(); tick();
        hold_pc = id_pc; hold_ins = id_ins;
        repeat (8) tick();
        #1;
        check_eq("stall_idv", 32'(id_valid), 32'd1);
        check_eq("stall_reqv", 32'(imem_req_valid), 32'd0);
        check_eq("stall_pc", id_pc, hold_pc);
        check_eq("stall_ins", id_ins, hold_ins);
        check_eq("stall_head", hold_pc, exp_pc);
        id_ready = 1'b1;
        run_until_pops(n_pops + 4, "stall_release", 30);

        // Drain with memory not ready; address must hold
        imem_req_ready = 1'b0;
        #1 hold_addr = imem_req_addr;
        for (int i = 0; i < 20 && (pq.size() > 0 || id_valid); i++) tick();
        check_eq("drain_done", 32'(pq.size() == 0 && !id_valid), 32'd1);
        check_eq("hold_addr", imem_req_addr, hold_addr);

        // Redirect with two requests in flight
        lat = 3; imem_req_ready = 1'b1;
        tick(); tick();
        #1;
        check_eq("two_inflight_reqv", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
        #1;
        check_eq("redir_reqv", 32'(imem_req_valid), 32'd0);
        check_eq("redir_idv", 32'(id_valid), 32'd0);
        exp_pc = 32'h0000_0100;
        acc_log.delete();
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 20 && acc_log.size() == 0; i++) tick();
        check_eq("redir_first_addr", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'h0000_0100);
        run_until_pops(n_pops + 1, "redir_first_pop", 20);
        lat = 1;
        run_until_pops(n_pops + 3, "redir_stream", 30);

        // Redirect coinciding with response and pop
        for (int i = 0; i < 20 && !(imem_resp_valid && id_valid); i++) tick();
        check_eq("co_setup", 32'(imem_resp_valid && id_valid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
        #1;
        check_eq("co_idv", 32'(id_valid), 32'd0);
        exp_pc = 32'h0000_0200;
        n0 = n_pops;
        tick();
        redirect_valid = 1'b0;
        #1;
        check_eq("co_flush", 32'(id_valid), 32'd0);
        check_eq("co_restart", 32'(imem_req_valid), 32'd1);
        check_eq("co_addr", imem_req_addr, 32'h0000_0200);
        check_eq("co_nopop", 32'(n_pops), 32'(n0));
        run_until_pops(n0 + 3, "co_stream", 30);

        // Address wrap
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        exp_pc = 32'hFFFF_FFFC;
        acc_log.delete();
        n0 = n_pops;
        tick();
        redirect_valid = 1'b0;
        run_until_pops(n0 + 3, "wrap_stream", 30);
        check_eq("wrap_a0", (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_DEAD, 32'hFFFF_FFFC);
        check_eq("wrap_a1", (acc_log.size() > 1) ? acc_log[1] : 32'hDEAD_DEAD, 32'h0000_0000);

        // Asynchronous reset with a full buffer
        id_ready = 1'b0;
        repeat (6) tick();
        #1;
        check_eq("full_idv", 32'(id_valid), 32'd1);
        check_eq("full_reqv", 32'(imem_req_valid), 32'd0);
        #2 rst_n = 1'b0;
        pq.delete();
        imem_resp_valid = 1'b0; imem_resp_data = '0;
        #1;
        check_eq("arst_reqv", 32'(imem_req_valid), 32'd0);
        check_eq("arst_idv", 32'(id_valid), 32'd0);
        check_eq("arst_ins", id_ins, 32'd0);
        check_eq("arst_pc", id_pc, 32'd0);
        check_eq("arst_addr", imem_req_addr, 32'd0);
        tick();
        #3 rst_n = 1'b1;
        #1;
        check_eq("arel_reqv", 32'(imem_req_valid), 32'd1);
        check_eq("arel_addr", imem_req_addr, 32'd0);
        exp_pc = 32'd0;
        id_ready = 1'b1;
        n0 = n_pops;
        run_until_pops(n0 + 4, "arel_stream", 30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
